// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional feature macro used by the top: RF_WB_ARBITER_STALL_CNT_EN.
package rf_wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREGS_DEF = 32;
    localparam int XLEN_DEF  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN_DEF-1:0]  xword_t;

endpackage

// File: rtl/rf_wen_onehot.sv
// One-hot decoder turning a registered destination index into per-register
// write enables; all enables stay low when en is low.
module rf_wen_onehot
    import rf_wb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF
) (
    input  logic                 en,
    input  logic [REG_IDX_W-1:0] sel,
    output logic [NREGS-1:0]     onehot
);

    // Decode sel into a single set bit, gated by en.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (en && (int'(sel) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NREQ writeback requesters. One grant per cycle, registered write one cycle
// later, one-hot write enable decoded from the registered index.
// Optional feature: define RF_WB_ARBITER_STALL_CNT_EN to add the saturating
// 16-bit stall_cnt output.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*REG_IDX_W-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wr_valid,
    output logic [REG_IDX_W-1:0]      wr_sel,
    output logic [XLEN-1:0]           wr_data,
    output logic [NREGS-1:0]          wr_en
`ifdef RF_WB_ARBITER_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    // A 1-bit pointer is kept for NREQ=1; it never leaves 0.
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     next_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;

    // Search req_valid from rr_ptr upward with wrap; flush suppresses every grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (!flush) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!grant_any && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
                end
            end
        end
    end

    // Grant vector, granted payload mux and the pointer value after this cycle.
    always_comb begin
        req_ready = '0;
        sel_rd    = '0;
        sel_data  = '0;
        next_ptr  = rr_ptr;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            next_ptr = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_rd   = req_rd[i*REG_IDX_W +: REG_IDX_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Pointer and write-port registers; writes to x0 are accepted but dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: wr_data is a plain datapath register, reset anyway so the
            // write port shows a defined value straight out of reset.
            rr_ptr   <= '0;
            wr_valid <= 1'b0;
            wr_sel   <= '0;
            wr_data  <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            rr_ptr <= next_ptr;
            if (grant_any && (sel_rd != '0)) begin
                wr_valid <= 1'b1;
                wr_sel   <= sel_rd;
                wr_data  <= sel_data;
            end else begin
                wr_valid <= 1'b0;
            end
        end
    end

    rf_wen_onehot #(
        .NREGS (NREGS)
    ) u_wen (
        .en     (wr_valid),
        .sel    (wr_sel),
        .onehot (wr_en)
    );

`ifdef RF_WB_ARBITER_STALL_CNT_EN
    logic stall_now;

    assign stall_now = |(req_valid & ~req_ready);

    // Count cycles with at least one valid but ungranted requester, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_now && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (NREQ=2, XLEN=32, NREGS=32).
// Inputs change on the falling edge; outputs are sampled 1 time unit after it
// (combinational grant) or 1 time unit after the rising edge (registered).
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        wr_valid;
    logic [4:0]  wr_sel;
    logic [31:0] wr_data;
    logic [31:0] wr_en;
`ifdef RF_WB_ARBITER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(
        .NREQ  (2),
        .XLEN  (32),
        .NREGS (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_valid  (wr_valid),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .wr_en     (wr_en)
`ifdef RF_WB_ARBITER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge and let the grant settle.
    task automatic drive(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic fl);
        @(negedge clk);
        req_valid = v;
        req_rd    = {rd1, rd0};
        req_data  = {d1, d0};
        flush     = fl;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
        #1;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL reset_wr_en: got %h expected 0", wr_en); end
        checks++; if (wr_sel !== 5'd0) begin errors++; $display("FAIL reset_wr_sel: got %0d expected 0", wr_sel); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        // A write to x9 from requester 0 moves the pointer to 1.
        drive(2'b01, 5'd9, 5'd0, 32'h1234_5678, 32'h0, 1'b0);
        after_edge();
        checks++; if (wr_en !== 32'h0000_0200) begin errors++; $display("FAIL pre_reset_write: got %h expected 00000200", wr_en); end
        // Pull reset mid-cycle while the write is still presented.
        @(negedge clk); req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL async_reset_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL async_reset_wr_en: got %h expected 0", wr_en); end
        checks++; if (wr_sel !== 5'd0) begin errors++; $display("FAIL async_reset_wr_sel: got %0d expected 0", wr_sel); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL async_reset_wr_data: got %h expected 0", wr_data); end
        @(negedge clk); rst_n = 1'b1;
        // Pointer is back at 0, so requester 0 wins with both valid.
        drive(2'b11, 5'd1, 5'd2, 32'hA, 32'hB, 1'b0);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", req_ready); end
        after_edge();
        checks++; if (wr_sel !== 5'd1) begin errors++; $display("FAIL reset_first_write_sel: got %0d expected 1", wr_sel); end
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        after_edge();
        // Pointer now 1.
    endtask

    task automatic test_single();
        drive(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        after_edge();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL single_wr_valid: got %b expected 1", wr_valid); end
        checks++; if (wr_sel !== 5'd5) begin errors++; $display("FAIL single_wr_sel: got %0d expected 5", wr_sel); end
        checks++; if (wr_en !== 32'h0000_0020) begin errors++; $display("FAIL single_wr_en: got %h expected 00000020", wr_en); end
        checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wr_data: got %h expected deadbeef", wr_data); end
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b expected 00", req_ready); end
        after_edge();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL idle_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL idle_wr_en: got %h expected 0", wr_en); end
        checks++; if (wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_wr_data_hold: got %h expected deadbeef", wr_data); end
        checks++; if (wr_sel !== 5'd5) begin errors++; $display("FAIL idle_wr_sel_hold: got %0d expected 5", wr_sel); end
        // Pointer now 1.
    endtask

    task automatic test_x0_drop();
        drive(2'b10, 5'd0, 5'd0, 32'h0, 32'hCAFE_F00D, 1'b0);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready: got %b expected 10", req_ready); end
        after_edge();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL x0_wr_valid: got %b expected 0", wr_valid); end
        checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL x0_wr_en: got %h expected 0", wr_en); end
        // The dropped request still advanced the pointer to 0.
        drive(2'b11, 5'd3, 5'd7, 32'h3333_3333, 32'h7777_7777, 1'b0);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL x0_next_grant: got %b expected 01", req_ready); end
        after_edge();
        checks++; if (wr_en !== 32'h0000_0008) begin errors++; $display("FAIL x0_next_wr_en: got %h expected 00000008", wr_en); end
        // Pointer now 1.
    endtask

    task automatic test_contention();
        // Pointer starts at 1, so requester 1 goes first.
        logic [1:0]  exp_rdy  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [31:0] exp_wen  [4] = '{32'h0000_0080, 32'h0000_0008, 32'h0000_0080, 32'h0000_0008};
        logic [31:0] exp_data [4] = '{32'h7777_7777, 32'h3333_3333, 32'h7777_7777, 32'h3333_3333};
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 5'd3, 5'd7, 32'h3333_3333, 32'h7777_7777, 1'b0);
            checks++; if (req_ready !== exp_rdy[i]) begin errors++; $display("FAIL contention_ready[%0d]: got %b expected %b", i, req_ready, exp_rdy[i]); end
            after_edge();
            checks++; if (wr_en !== exp_wen[i]) begin errors++; $display("FAIL contention_wr_en[%0d]: got %h expected %h", i, wr_en, exp_wen[i]); end
            checks++; if (wr_data !== exp_data[i]) begin errors++; $display("FAIL contention_wr_data[%0d]: got %h expected %h", i, wr_data, exp_data[i]); end
        end
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        after_edge();
        // Pointer now 1.
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 5'd3, 5'd7, 32'h3333_3333, 32'h7777_7777, 1'b1);
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_ready[%0d]: got %b expected 00", i, req_ready); end
            after_edge();
            checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL flush_wr_valid[%0d]: got %b expected 0", i, wr_valid); end
            checks++; if (wr_en !== 32'h0) begin errors++; $display("FAIL flush_wr_en[%0d]: got %h expected 0", i, wr_en); end
        end
        // Pointer held at 1 through the flush.
        drive(2'b11, 5'd3, 5'd7, 32'h3333_3333, 32'h7777_7777, 1'b0);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL post_flush_grant: got %b expected 10", req_ready); end
        after_edge();
        checks++; if (wr_sel !== 5'd7) begin errors++; $display("FAIL post_flush_wr_sel: got %0d expected 7", wr_sel); end
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        after_edge();
    endtask

`ifdef RF_WB_ARBITER_STALL_CNT_EN
    task automatic test_stall_cnt();
        @(negedge clk); rst_n = 1'b0; req_valid = 2'b00; flush = 1'b0;
        #1;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_reset: got %0d expected 0", stall_cnt); end
        @(negedge clk); rst_n = 1'b1;
        drive(2'b11, 5'd3, 5'd7, 32'h1, 32'h2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_contention: got %0d expected 10", stall_cnt); end
        // A lone requester is always granted: no stall.
        drive(2'b01, 5'd3, 5'd7, 32'h1, 32'h2, 1'b0);
        after_edge();
        checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_single_no_inc: got %0d expected 10", stall_cnt); end
        drive(2'b11, 5'd3, 5'd7, 32'h1, 32'h2, 1'b1);
        repeat (70000) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h expected ffff", stall_cnt); end
        after_edge();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_hold_max: got %h expected ffff", stall_cnt); end
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_x0_drop();
        test_contention();
        test_flush();
`ifdef RF_WB_ARBITER_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback requesters (e.g. ALU result, load return).
- Each cycle, picks one valid requester round-robin and registers its destination index and data.
- Drives the one-hot per-register write enable the next cycle.
- Sits between the execute/memory writeback sources and the register file array.

Parameters:
- NREQ, 2, number of writeback requesters (2..8).
- XLEN, 32, data width.
- NREGS, 32, register count; index width fixed at 5.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; no grants while high.
- req_valid  in  NREQ  per-requester write request.
- req_rd  in  NREQ*5  destination index; requester i at bits [5i+4:5i].
- req_data  in  NREQ*XLEN  write data; requester i at slice i.
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] && req_ready[i].
- wr_valid  out  1  registered write strobe.
- wr_sel  out  5  registered destination index.
- wr_data  out  XLEN  registered write data.
- wr_en  out  NREGS  one-hot write enable; all zero when wr_valid=0.
- stall_cnt  out  16  present only with the optional feature.

Behaviour:
- Reset is asynchronous, active-low.
  - Reset values: wr_valid=0, wr_sel=0, wr_data=0, wr_en=0, rr_ptr=0, stall_cnt=0.
  - Asserting rst_n low mid-transfer discards the in-flight write.
- Grant (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first valid index gets req_ready=1. At most one bit of req_ready is set.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- flush=1 forces req_ready=0. Flush takes priority over all grants.
- Pointer:
  - On a transfer from index g: rr_ptr <= (g+1) mod NREQ.
  - With no transfer, or during flush: rr_ptr holds.
- Output stage, latency 1 cycle from accept to write:
  - On a transfer with rd!=0: wr_valid<=1, wr_sel<=rd, wr_data<=data.
  - On a transfer with rd==0: the request is accepted (ready=1, pointer advances) but dropped; wr_valid<=0.
  - With no transfer: wr_valid<=0. wr_sel and wr_data hold their last values.
- wr_en = wr_valid ? one-hot(wr_sel) : 0.
  - Decoded combinationally from registers only; no input-to-wr_en path.
- The register file never back-pressures: a write is always taken the cycle wr_valid=1.
- A requester not granted keeps req_valid and its rd/data stable until granted.
- NREQ=1 degenerates to a pass-through register with rr_ptr constant 0.

Optional Feature:
- Macro: RF_WB_ARBITER_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists, a 16-bit counter.
  - Increments by 1 each cycle in which some req_valid[i]=1 has req_ready[i]=0. This includes flush cycles with pending requests.
  - Increments by at most 1 per cycle.
  - Saturates at 0xFFFF; reset to 0 by rst_n.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package rf_wb_pkg:
  - REG_IDX_W=5, NREGS_DEF=32, XLEN_DEF=32.
  - typedef reg_idx_t (5-bit) and typedef xword_t (XLEN_DEF-bit).
- Sub-module rf_wen_onehot:
  - Parameterised NREGS-bit one-hot decoder with an enable input.
  - Output all zero when enable=0.
  - Instantiated once on wr_sel/wr_valid.

Test Plan:
- Reset: pulse rst_n low mid-write with wr_valid=1 → wr_valid, wr_en, wr_sel, wr_data go 0 immediately, without a clock edge; first grant after release goes to requester 0 when all are valid.
- Single request: req_valid=2'b01, req_rd[0]=5, req_data[0]=0xDEADBEEF → req_ready=2'b01 same cycle; next cycle wr_valid=1, wr_sel=5, wr_en=0x00000020, wr_data=0xDEADBEEF.
- Contention: req_valid=2'b11 held, rd0=3, rd1=7 → req_ready alternates 01,10,01,10; wr_en alternates 0x00000008, 0x00000080 from one cycle later.
- x0 drop: req_valid=2'b10, req_rd[1]=0 → req_ready=2'b10; next cycle wr_valid=0, wr_en=0; then req_valid=2'b11 grants requester 0 (pointer advanced to 0).
- Flush: flush=1 with req_valid=2'b11 for 3 cycles → req_ready=0, wr_valid=0 throughout; pointer unchanged, so the first grant after flush drops matches the pre-flush order.
- Stall counter (macro defined): req_valid=2'b11 for 10 cycles → stall_cnt=10; hold both valid with flush=1 for 70000 cycles → stall_cnt=0xFFFF and stays there.
